// File: rtl/dsp_pkg.sv
// dsp_pkg: shared widths and loader state encoding for the dRAM window loader.
package dsp_pkg;
  localparam int DEF_ADDR_W = 19;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DIM_W  = 10;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} loader_state_t;
endpackage

// File: rtl/win_addr_gen.sv
// win_addr_gen: incremental row/column address walker for a rectangular window.
module win_addr_gen
  import dsp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DIM_W  = DEF_DIM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [DIM_W-1:0]  w_q, h_q, row, col;
  logic [ADDR_W-1:0] stride_q, row_base;
  logic              row_end;
  assign row_end = col == w_q - DIM_W'(1);
  assign last    = row_end && row == h_q - DIM_W'(1);
  // Sums wrap naturally at ADDR_W bits; no multiplier needed.
  assign addr    = row_base + ADDR_W'(col);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_q      <= '0;
      h_q      <= '0;
      stride_q <= '0;
      row      <= '0;
      col      <= '0;
      row_base <= '0;
    end else if (load) begin
      w_q      <= width;
      h_q      <= height;
      stride_q <= stride;
      row      <= '0;
      col      <= '0;
      row_base <= base;
    end else if (step) begin
      col      <= row_end ? '0 : col + DIM_W'(1);
      row      <= row_end ? row + DIM_W'(1) : row;
      row_base <= row_end ? row_base + stride_q : row_base;
    end
endmodule

// File: rtl/dram_window_loader.sv
// dram_window_loader: streams bytes into a rectangular dRAM window; optional DRAM_LOADER_CHECKSUM_EN adds a byte checksum.
module dram_window_loader
  import dsp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIM_W  = DEF_DIM_W
) (
  input  logic              clk,
  input  logic              power_ON,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  win_width,
  input  logic [DIM_W-1:0]  win_height,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] dRamAddr,
  output logic [DATA_W-1:0] dRamIn,
  output logic              dRamWrEn,
  output logic              busy,
  output logic              done
`ifdef DRAM_LOADER_CHECKSUM_EN
  ,output logic [15:0]      checksum
`endif
);
  loader_state_t     state, nxt;
  logic              accept, zero, last, load;
  logic [ADDR_W-1:0] addr;
  assign accept = in_valid && in_ready;
  assign zero   = win_width == '0 || win_height == '0;
  assign load   = state == IDLE && start;
  win_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_gen (
    .clk   (clk),
    .rst   (power_ON),
    .load  (load),
    .step  (accept),
    .base  (base_addr),
    .width (win_width),
    .height(win_height),
    .stride(row_stride),
    .addr  (addr),
    .last  (last)
  );
  always_ff @(posedge clk or posedge power_ON)
    if (power_ON) state <= IDLE;
    else          state <= nxt;
  always_comb
    nxt = state == IDLE  ? (start ? (zero ? DONE : LOAD) : IDLE) :
          state == LOAD  ? (accept && last ? DRAIN : LOAD) :
          state == DRAIN ? DONE : IDLE;
  always_comb begin
    in_ready = state == LOAD;
    busy     = state != IDLE;
    done     = state == DONE;
  end
  // One-cycle registered write port; strobe only follows an accepted beat.
  always_ff @(posedge clk or posedge power_ON)
    if (power_ON) begin
      dRamWrEn <= 1'b0;
      dRamAddr <= '0;
      dRamIn   <= '0;
    end else begin
      dRamWrEn <= accept;
      if (accept) begin
        dRamAddr <= addr;
        dRamIn   <= in_data;
      end
    end
`ifdef DRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge power_ON)
    if (power_ON)      checksum <= '0;
    else if (load)     checksum <= '0;
    else if (dRamWrEn) checksum <= checksum + 16'(dRamIn);
`endif
endmodule

// File: tb/tb_dram_window_loader.sv
// tb_dram_window_loader: randomized self-checking bench for dram_window_loader against a loop-based window model.
module tb_dram_window_loader;
  logic        clk = 0, power_ON = 1, start = 0, in_valid = 0;
  logic [18:0] base_addr = 0, row_stride = 0, dRamAddr;
  logic [9:0]  win_width = 0, win_height = 0;
  logic [7:0]  in_data = 0, dRamIn;
  logic        in_ready, dRamWrEn, busy, done;
`ifdef DRAM_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif
  int n_checks = 0, n_pass = 0, cyc = 0;
  int wa[$], wd[$], ea[$], ed[$];
  int done_cnt = 0, done_cyc = 0, acc_cyc = 0, rdy_cnt = 0, bad_wren = 0;
  bit prev_acc = 0;
  int exp_sum = 0;

  dram_window_loader dut (
    .clk(clk), .power_ON(power_ON), .start(start), .base_addr(base_addr),
    .win_width(win_width), .win_height(win_height), .row_stride(row_stride),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .dRamAddr(dRamAddr), .dRamIn(dRamIn), .dRamWrEn(dRamWrEn),
    .busy(busy), .done(done)
`ifdef DRAM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dRamWrEn) begin
      wa.push_back(int'(dRamAddr));
      wd.push_back(int'(dRamIn));
      if (!prev_acc) bad_wren++;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (in_ready) rdy_cnt++;
    if (in_valid && in_ready) acc_cyc = cyc;
    prev_acc = in_valid && in_ready;
  end

  task automatic build_model(input int base, input int w, input int h, input int stride, input bit seq);
    ea.delete(); ed.delete(); exp_sum = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        ea.push_back((base + r * stride + c) % (1 << 19));
        ed.push_back(seq ? (r * w + c) % 256 : int'($urandom_range(0, 255)));
        exp_sum = (exp_sum + ed[$]) % 65536;
      end
  endtask

  task automatic load_window(input int base, input int w, input int h, input int stride,
                             input int mode, input bit seq, input string nm);
    int n, idx, budget;
    bit acc;
    n = w * h;
    build_model(base, w, h, stride, seq);
    wa.delete(); wd.delete(); done_cnt = 0; bad_wren = 0; rdy_cnt = 0;
    @(posedge clk); #1;
    base_addr = 19'(base); win_width = 10'(w); win_height = 10'(h); row_stride = 19'(stride);
    start = 1; in_valid = 1;
    @(posedge clk); #1;
    start = 0;
    n_checks++;
    if (n == 0) begin
      if (done !== 1'b1) $display("FAIL %s zero_done_t+1 got %b exp 1", nm, done); else n_pass++;
    end else begin
      if (in_ready !== 1'b1) $display("FAIL %s ready_t+1 got %b exp 1", nm, in_ready); else n_pass++;
    end
`ifdef DRAM_LOADER_CHECKSUM_EN
    n_checks++;
    if (checksum !== 16'h0) $display("FAIL %s checksum_clear got %0h exp 0", nm, checksum); else n_pass++;
`endif
    idx = 0; budget = 0;
    while (idx < n && budget < n * 4 + 20) begin
      in_valid = mode == 0 ? 1'b1 : mode == 1 ? (budget % 2 == 0) : 1'($urandom_range(0, 1));
      in_data = 8'(ed[idx]);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      budget++;
    end
    in_valid = 0;
    if (idx < n) begin
      n_checks++;
      $display("FAIL %s feed_timeout got %0d beats exp %0d", nm, idx, n);
    end
    for (int k = 0; k < 8 && done_cnt == 0; k++) @(negedge clk);
`ifdef DRAM_LOADER_CHECKSUM_EN
    n_checks++;
    if (checksum !== 16'(exp_sum)) $display("FAIL %s checksum got %0d exp %0d", nm, checksum, exp_sum); else n_pass++;
`endif
    n_checks++;
    if (done_cnt !== 1) $display("FAIL %s done_count got %0d exp 1", nm, done_cnt); else n_pass++;
    if (n > 0) begin
      n_checks++;
      if (done_cyc - acc_cyc !== 2) $display("FAIL %s done_latency got %0d exp 2", nm, done_cyc - acc_cyc); else n_pass++;
    end else begin
      n_checks++;
      if (rdy_cnt !== 0) $display("FAIL %s ready_cycles got %0d exp 0", nm, rdy_cnt); else n_pass++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s idle_after_done busy got %b exp 0", nm, busy); else n_pass++;
    n_checks++;
    if (wa.size() !== n) $display("FAIL %s write_count got %0d exp %0d", nm, wa.size(), n); else n_pass++;
    for (int i = 0; i < n && i < wa.size(); i++) begin
      n_checks++;
      if (wa[i] !== ea[i] || wd[i] !== ed[i])
        $display("FAIL %s write[%0d] got %0h=%0h exp %0h=%0h", nm, i, wa[i], wd[i], ea[i], ed[i]);
      else n_pass++;
    end
    n_checks++;
    if (bad_wren !== 0) $display("FAIL %s wren_after_nonaccept got %0d exp 0", nm, bad_wren); else n_pass++;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({in_ready, dRamWrEn, busy, done} !== 4'b0 || dRamAddr !== 19'h0 || dRamIn !== 8'h0)
      $display("FAIL reset_outputs got %b%b%b%b %0h %0h exp all 0", in_ready, dRamWrEn, busy, done, dRamAddr, dRamIn);
    else n_pass++;
    @(posedge clk); #1; power_ON = 0;
  endtask

  task automatic test_main;      load_window(23, 11, 10, 12, 0, 1, "main");   endtask
  task automatic test_toggle;    load_window(23, 11, 10, 12, 1, 1, "toggle"); endtask
  task automatic test_zero;      load_window(100, 0, 5, 3, 0, 1, "zero");     endtask
  task automatic test_wrap;      load_window(19'h7FFFE, 4, 1, 9, 0, 0, "wrap"); endtask

  task automatic test_random;
    for (int t = 0; t < 3; t++)
      load_window(int'($urandom_range(0, 524287)), int'($urandom_range(1, 9)), int'($urandom_range(1, 6)),
                  int'($urandom_range(0, 20)), 2, 0, "random");
  endtask

  task automatic test_reset_mid;
    build_model(23, 11, 10, 12, 1);
    wa.delete(); wd.delete(); done_cnt = 0;
    @(posedge clk); #1;
    base_addr = 23; win_width = 11; win_height = 10; row_stride = 12; start = 1;
    @(posedge clk); #1;
    start = 0; in_valid = 1;
    for (int i = 0; i < 50; i++) begin
      in_data = 8'(ed[i]);
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    power_ON = 1;
    #1;
    n_checks++;
    if ({in_ready, dRamWrEn, busy, done} !== 4'b0 || dRamAddr !== 19'h0 || dRamIn !== 8'h0)
      $display("FAIL midreset_outputs got %b%b%b%b %0h %0h exp all 0", in_ready, dRamWrEn, busy, done, dRamAddr, dRamIn);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (wa.size() !== 50 || done_cnt !== 0)
      $display("FAIL midreset_writes got %0d writes %0d done exp 50 writes 0 done", wa.size(), done_cnt);
    else n_pass++;
    for (int i = 0; i < 50 && i < wa.size(); i++) begin
      n_checks++;
      if (wa[i] !== ea[i] || wd[i] !== ed[i])
        $display("FAIL midreset_write[%0d] got %0h=%0h exp %0h=%0h", i, wa[i], wd[i], ea[i], ed[i]);
      else n_pass++;
    end
    @(posedge clk); #1;
    in_valid = 0; power_ON = 0;
    load_window(23, 11, 10, 12, 0, 1, "reload");
  endtask

  task automatic test_back_to_back;
    load_window(5, 3, 3, 2, 0, 0, "b2b_a");
    load_window(40, 5, 2, 7, 2, 0, "b2b_b");
  endtask

  initial begin
    test_reset;
    test_main;
    test_toggle;
    test_zero;
    test_wrap;
    test_random;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dram_window_loader.md
# dram_window_loader

Writes a rectangular pixel window into the processor's data RAM from an 8-bit valid/ready byte stream. It is the write-side counterpart to the post-run dRAM window dump: it preloads the source image, or any sub-window of it, before the downsampling processor is started. It sits between the host/stream source and the dRAM write port, and is the only dRAM writer while `busy` is high.

## Interface
Parameters:
- `ADDR_W`, 19, dRAM address width
- `DATA_W`, 8, pixel width
- `DIM_W`, 10, width of the window width/height counters

Ports:
- `clk`  in  1  system clock, 50 MHz
- `power_ON`  in  1  reset; asynchronous, active-high
- `start`  in  1  one-cycle request to begin a window load
- `base_addr`  in  ADDR_W  dRAM address of window pixel (0,0)
- `win_width`  in  DIM_W  pixels per window row
- `win_height`  in  DIM_W  window rows
- `row_stride`  in  ADDR_W  address step between row starts
- `in_data`  in  DATA_W  stream pixel
- `in_valid`  in  1  stream pixel valid
- `in_ready`  out  1  loader accepts pixel
- `dRamAddr`  out  ADDR_W  dRAM write address
- `dRamIn`  out  DATA_W  dRAM write data
- `dRamWrEn`  out  1  dRAM write strobe
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE: `start`=1 latches `base_addr`, `win_width`, `win_height` and `row_stride`, clears `row` and `col`, sets `row_base`=`base_addr`, and goes to LOAD. If width or height is 0, it goes straight to DONE with no writes.
- LOAD: `in_ready`=1 combinationally.
  - A beat is accepted when `in_valid` and `in_ready` are both high.
  - On each accepted beat, `dRamAddr` is registered as `row_base`+`col` and `dRamIn` as `in_data`.
  - On each accepted beat, `dRamWrEn`=1 for exactly the next cycle.
- Column and row stepping:
  - `col` increments on each accepted beat.
  - When `col`=`win_width`-1: `col` returns to 0, `row` increments, and `row_base` += `row_stride`.
- Accepting the final beat (`row`=`win_height`-1 and `col`=`win_width`-1) moves to DRAIN. The last write occurs in DRAIN.
- DRAIN moves to DONE unconditionally. DONE asserts `done` and moves to IDLE.
- Addresses are computed incrementally with no multiplier. Address sums wrap modulo 2^ADDR_W; there is no saturation and no error.
- `row_stride` < `win_width` is legal, and overlapping addresses are simply rewritten.
- `start` outside IDLE is ignored.
- `in_valid` outside LOAD is ignored, and no data is consumed.
- `busy`=1 in LOAD and DRAIN, and in DONE.

## Timing
- Reset values:
  - `in_ready`=0, `dRamWrEn`=0, `busy`=0, `done`=0.
  - `dRamAddr`=0, `dRamIn`=0.
  - State is IDLE and all counters are 0.
- Reset asserted mid-load aborts immediately. No further writes occur, no `done` pulse is issued, and the partially written window is left in place.
- `start` at cycle t puts the block in LOAD at t+1, with `in_ready` high at t+1.
- A beat accepted at cycle t produces its write strobe at t+1. Throughput is 1 pixel/clock.
- The last beat accepted at t produces its last write at t+1 (DRAIN), `done` at t+2, and IDLE at t+3, where `start` is accepted again.
- With a zero-size window, `start` at t gives `done` at t+1 and no `dRamWrEn`.
- `in_valid` may drop at any time in LOAD. Counters hold, and `dRamWrEn` is 0 in the cycle after a non-accepted cycle.

## Configuration
- `DRAM_LOADER_CHECKSUM_EN` defined:
  - Adds output `checksum` [15:0].
  - It is a modulo-2^16 sum of all bytes written in the current load.
  - It is cleared on accepted `start` and on reset, and is valid (stable) from the `done` cycle until the next `start`.
- Not defined: the port and the adder are absent, and behaviour is otherwise identical.

## Structure
- Shared package `dsp_pkg`: `ADDR_W`/`DATA_W`/`DIM_W` defaults and the state enum `loader_state_t`.
- One sub-module, `win_addr_gen`:
  - Holds `row`, `col` and `row_base`.
  - Inputs: `load` (latch geometry), `step` (accepted beat).
  - Outputs: `addr` and `last`.
- The FSM and the write register stay in `dram_window_loader`.

## Test plan
- Window with base 23, width 11, height 10, stride 12, streaming bytes 0..109 continuously:
  - Writes go to 23..33 = 0..10, then 35..45 = 11..21, …, with the last write at 131..141 = 99..109.
  - 110 write strobes in total; `done` 2 cycles after the last accept.
- Same window with `in_valid` toggled every other cycle: identical address/data sequence, and `dRamWrEn` never high in a cycle following a non-accept.
- Width 0, height 5: `done` the cycle after `start`, zero writes, `in_ready` never high.
- Base 0x7FFFE, width 4, height 1: addresses 0x7FFFE, 0x7FFFF, 0x00000, 0x00001 (wrap).
- Reset at the 50th accepted beat of the first scenario: all outputs 0 on the next edge, no `done` pulse, and a fresh `start` then reloads correctly.
- `DRAM_LOADER_CHECKSUM_EN` with the first scenario: `checksum` = 5995 (0x176B) at `done`; a second `start` clears it to 0.
